// File: rtl/pipeline_pkg.sv
// Shared pipeline types: operand/address widths, ALU op encoding and the
// EX-stage control bundle carried through the ID/EX register.
package pipeline_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    memToReg;
    logic    aluSrc;
    alu_op_e aluOp;
  } ex_ctrl_t;

  // A bubble writes nothing and touches no memory, so forwarding never matches it.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: freezes PC and IF/ID for one cycle when the load
// sitting in ID/EX produces a register the decoding instruction reads.
module hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_flush,
  output logic              load_use,
  output logic              pc_write,
  output logic              if_id_write
);

  // Compare the load's destination against the decoding instruction's sources.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    load_use    = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (ex_valid && ex_mem_read && id_valid &&
        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)))) begin
      load_use = 1'b1;
    end
    // A taken branch kills the dependent instruction, so there is nothing to hold.
    pc_write    = !load_use || ex_flush;
    if_id_write = !load_use || ex_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard detection and a
// saturating stall counter. Bubbles are inserted on flush or load-use.
module id_ex_stage #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int REG_AW = pipeline_pkg::REG_AW,
  parameter int CNT_W  = pipeline_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic [2:0]        id_aluOp,
  input  logic              ex_flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ID_EX_valid,
  output logic [REG_AW-1:0] ID_EX_Rs,
  output logic [REG_AW-1:0] ID_EX_Rt,
  output logic [REG_AW-1:0] ID_EX_wreg,
  output logic [DATA_W-1:0] ID_EX_rdata1,
  output logic [DATA_W-1:0] ID_EX_rdata2,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic              ID_EX_regWrite,
  output logic              ID_EX_memRead,
  output logic              ID_EX_memWrite,
  output logic              ID_EX_memToReg,
  output logic              ID_EX_aluSrc,
  output logic [2:0]        ID_EX_aluOp,
  output logic [CNT_W-1:0]  stall_count
);

  import pipeline_pkg::*;

  ex_ctrl_t          id_ctrl;
  ex_ctrl_t          ctrl_q;
  logic              valid_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] wreg_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;
  logic [DATA_W-1:0] imm_q;
  logic [CNT_W-1:0]  stall_q;
  logic              load_use;

  // Bundle decoded control; an empty decode slot carries no side effects.
  always_comb begin
    id_ctrl = EX_CTRL_BUBBLE;
    if (id_valid) begin
      id_ctrl.regWrite = id_regWrite;
      id_ctrl.memRead  = id_memRead;
      id_ctrl.memWrite = id_memWrite;
      id_ctrl.memToReg = id_memToReg;
      id_ctrl.aluSrc   = id_aluSrc;
      id_ctrl.aluOp    = alu_op_e'(id_aluOp);
    end
  end

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.memRead),
    .ex_rt       (rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_flush    (ex_flush),
    .load_use    (load_use),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Pipeline register: reset, then flush/stall bubble, else capture decode.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ctrl_q   <= EX_CTRL_BUBBLE;
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      stall_q  <= '0;
    end else begin
      if (ex_flush || load_use) begin
        ctrl_q   <= EX_CTRL_BUBBLE;
        valid_q  <= 1'b0;
        rs_q     <= '0;
        rt_q     <= '0;
        wreg_q   <= '0;
        rdata1_q <= '0;
        rdata2_q <= '0;
        imm_q    <= '0;
      end else begin
        ctrl_q   <= id_ctrl;
        valid_q  <= id_valid;
        rs_q     <= id_rs;
        rt_q     <= id_rt;
        wreg_q   <= id_regDst ? id_rd : id_rt;
        rdata1_q <= id_rdata1;
        rdata2_q <= id_rdata2;
        imm_q    <= id_imm;
      end
      // Only a real stall counts; a flush overrides it and frees the pipe.
      if (load_use && !ex_flush && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign ID_EX_valid    = valid_q;
  assign ID_EX_Rs       = rs_q;
  assign ID_EX_Rt       = rt_q;
  assign ID_EX_wreg     = wreg_q;
  assign ID_EX_rdata1   = rdata1_q;
  assign ID_EX_rdata2   = rdata2_q;
  assign ID_EX_imm      = imm_q;
  assign ID_EX_regWrite = ctrl_q.regWrite;
  assign ID_EX_memRead  = ctrl_q.memRead;
  assign ID_EX_memWrite = ctrl_q.memWrite;
  assign ID_EX_memToReg = ctrl_q.memToReg;
  assign ID_EX_aluSrc   = ctrl_q.aluSrc;
  assign ID_EX_aluOp    = ctrl_q.aluOp;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model pushes the expected
// ID/EX contents to a scoreboard before each edge; they are popped and
// compared after the edge. Hazard outputs are checked before each edge.
module tb_id_ex_stage;

  import pipeline_pkg::*;

  typedef struct {
    logic              rst;
    logic              flush;
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              uses_rt;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              aluSrc;
    logic              regDst;
    logic [2:0]        aluOp;
  } stim_t;

  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              aluSrc;
    logic [2:0]        aluOp;
    logic [CNT_W-1:0]  stall;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm;
  logic              id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
  logic [2:0]        id_aluOp;
  logic              ex_flush;
  logic              pc_write, if_id_write;
  logic              ID_EX_valid;
  logic [REG_AW-1:0] ID_EX_Rs, ID_EX_Rt, ID_EX_wreg;
  logic [DATA_W-1:0] ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
  logic              ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg, ID_EX_aluSrc;
  logic [2:0]        ID_EX_aluOp;
  logic [CNT_W-1:0]  stall_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t model;
  logic model_known = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_uses_rt     (id_uses_rt),
    .id_rdata1      (id_rdata1),
    .id_rdata2      (id_rdata2),
    .id_imm         (id_imm),
    .id_regWrite    (id_regWrite),
    .id_memRead     (id_memRead),
    .id_memWrite    (id_memWrite),
    .id_memToReg    (id_memToReg),
    .id_aluSrc      (id_aluSrc),
    .id_regDst      (id_regDst),
    .id_aluOp       (id_aluOp),
    .ex_flush       (ex_flush),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .ID_EX_valid    (ID_EX_valid),
    .ID_EX_Rs       (ID_EX_Rs),
    .ID_EX_Rt       (ID_EX_Rt),
    .ID_EX_wreg     (ID_EX_wreg),
    .ID_EX_rdata1   (ID_EX_rdata1),
    .ID_EX_rdata2   (ID_EX_rdata2),
    .ID_EX_imm      (ID_EX_imm),
    .ID_EX_regWrite (ID_EX_regWrite),
    .ID_EX_memRead  (ID_EX_memRead),
    .ID_EX_memWrite (ID_EX_memWrite),
    .ID_EX_memToReg (ID_EX_memToReg),
    .ID_EX_aluSrc   (ID_EX_aluSrc),
    .ID_EX_aluOp    (ID_EX_aluOp),
    .stall_count    (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst      = 1'b0;
    s.flush    = 1'b0;
    s.valid    = 1'($urandom_range(0, 3) != 0);
    s.rs       = REG_AW'($urandom);
    s.rt       = REG_AW'($urandom);
    s.rd       = REG_AW'($urandom);
    s.uses_rt  = 1'($urandom);
    s.rdata1   = DATA_W'($urandom);
    s.rdata2   = DATA_W'($urandom);
    s.imm      = DATA_W'($urandom);
    s.regWrite = 1'($urandom);
    s.memRead  = 1'($urandom_range(0, 2) == 0);
    s.memWrite = 1'($urandom);
    s.memToReg = 1'($urandom);
    s.aluSrc   = 1'($urandom);
    s.regDst   = 1'($urandom);
    s.aluOp    = 3'($urandom);
    return s;
  endfunction

  // Quiet instruction with no register dependencies worth matching.
  function automatic stim_t nop_stim();
    stim_t s;
    s = rand_stim();
    s.valid   = 1'b1;
    s.memRead = 1'b0;
    return s;
  endfunction

  function automatic stim_t load_stim(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt);
    stim_t s;
    s = nop_stim();
    s.rs = rs; s.rt = rt;
    s.memRead = 1'b1; s.regWrite = 1'b1; s.memToReg = 1'b1;
    s.aluSrc = 1'b1; s.regDst = 1'b0; s.memWrite = 1'b0;
    return s;
  endfunction

  function automatic stim_t use_stim(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                                     input logic uses_rt);
    stim_t s;
    s = nop_stim();
    s.rs = rs; s.rt = rt; s.uses_rt = uses_rt;
    return s;
  endfunction

  // Drive one cycle, check hazard outputs, predict and then compare ID/EX.
  task automatic step(input stim_t s);
    exp_t nx;
    logic lu;
    exp_t got_e;
    @(negedge clk);
    rst = s.rst; ex_flush = s.flush; id_valid = s.valid;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_uses_rt = s.uses_rt;
    id_rdata1 = s.rdata1; id_rdata2 = s.rdata2; id_imm = s.imm;
    id_regWrite = s.regWrite; id_memRead = s.memRead; id_memWrite = s.memWrite;
    id_memToReg = s.memToReg; id_aluSrc = s.aluSrc; id_regDst = s.regDst; id_aluOp = s.aluOp;
    #1;
    lu = 1'b0;
    if (model_known) begin
      lu = model.valid && model.memRead && s.valid &&
           ((model.rt == s.rs) || (s.uses_rt && (model.rt == s.rt)));
      check("pc_write", 32'(pc_write), 32'(!lu || s.flush));
      check("if_id_write", 32'(if_id_write), 32'(!lu || s.flush));
    end
    nx = '{default: '0};
    if (s.rst) begin
      nx = '{default: '0};
    end else if (s.flush || lu) begin
      nx.stall = model.stall;
      if (lu && !s.flush && model.stall != 8'd255) nx.stall = model.stall + 8'd1;
    end else begin
      nx.valid  = s.valid;
      nx.rs     = s.rs;
      nx.rt     = s.rt;
      nx.wreg   = s.regDst ? s.rd : s.rt;
      nx.rdata1 = s.rdata1;
      nx.rdata2 = s.rdata2;
      nx.imm    = s.imm;
      if (s.valid) begin
        nx.regWrite = s.regWrite; nx.memRead = s.memRead; nx.memWrite = s.memWrite;
        nx.memToReg = s.memToReg; nx.aluSrc = s.aluSrc; nx.aluOp = s.aluOp;
      end
      nx.stall = model.stall;
    end
    if (model_known || s.rst) sb_q.push_back(nx);
    model = nx;
    @(posedge clk);
    #1;
    if (model_known || s.rst) begin
      got_e = sb_q.pop_front();
      check("valid",    32'(ID_EX_valid),    32'(got_e.valid));
      check("rs",       32'(ID_EX_Rs),       32'(got_e.rs));
      check("rt",       32'(ID_EX_Rt),       32'(got_e.rt));
      check("wreg",     32'(ID_EX_wreg),     32'(got_e.wreg));
      check("regWrite", 32'(ID_EX_regWrite), 32'(got_e.regWrite));
      check("memRead",  32'(ID_EX_memRead),  32'(got_e.memRead));
      check("memWrite", 32'(ID_EX_memWrite), 32'(got_e.memWrite));
      check("memToReg", 32'(ID_EX_memToReg), 32'(got_e.memToReg));
      check("aluSrc",   32'(ID_EX_aluSrc),   32'(got_e.aluSrc));
      check("aluOp",    32'(ID_EX_aluOp),    32'(got_e.aluOp));
      check("stall",    32'(stall_count),    32'(got_e.stall));
      if (got_e.valid) begin
        check("rdata1", 32'(ID_EX_rdata1), 32'(got_e.rdata1));
        check("rdata2", 32'(ID_EX_rdata2), 32'(got_e.rdata2));
        check("imm",    32'(ID_EX_imm),    32'(got_e.imm));
      end
    end
    if (s.rst) model_known = 1'b1;
  endtask

  initial begin
    stim_t s;
    rst = 1'b1; ex_flush = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rt = 1'b0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
    id_regWrite = 1'b0; id_memRead = 1'b0; id_memWrite = 1'b0;
    id_memToReg = 1'b0; id_aluSrc = 1'b0; id_regDst = 1'b0; id_aluOp = '0;

    // Reset held two cycles with random decode inputs.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b1;
      step(s);
    end
    check("reset_valid", 32'(ID_EX_valid), 32'd0);
    check("reset_stall", 32'(stall_count), 32'd0);

    // Plain capture.
    s = nop_stim();
    s.rs = 3'd3; s.rt = 3'd5; s.rd = 3'd6; s.regDst = 1'b1; s.regWrite = 1'b1;
    s.rdata1 = 16'h1234;
    step(s);
    check("cap_pc_write", 32'(pc_write), 32'd1);
    check("cap_wreg", 32'(ID_EX_wreg), 32'd6);
    check("cap_rdata1", 32'(ID_EX_rdata1), 32'h1234);

    // Load-use on rs: one stall, then the held instruction enters.
    step(load_stim(3'd1, 3'd2));
    s = use_stim(3'd2, 3'd0, 1'b1);
    step(s);
    check("lu_regWrite", 32'(ID_EX_regWrite), 32'd0);
    check("lu_stall1", 32'(stall_count), 32'd1);
    step(s);
    check("lu_held_rs", 32'(ID_EX_Rs), 32'd2);
    check("lu_held_valid", 32'(ID_EX_valid), 32'd1);

    // rt-only dependency: ignored without uses_rt, stalls with it.
    step(load_stim(3'd0, 3'd4));
    step(use_stim(3'd1, 3'd4, 1'b0));
    check("rt_nostall", 32'(stall_count), 32'd1);
    step(load_stim(3'd0, 3'd4));
    s = use_stim(3'd1, 3'd4, 1'b1);
    step(s);
    check("rt_stall", 32'(stall_count), 32'd2);
    step(s);

    // Back-to-back dependent loads: one stall each.
    step(load_stim(3'd0, 3'd1));
    s = load_stim(3'd1, 3'd3);
    step(s);
    step(s);
    s = use_stim(3'd3, 3'd7, 1'b0);
    step(s);
    step(s);
    check("b2b_stall", 32'(stall_count), 32'd4);

    // Flush beats load-use.
    step(load_stim(3'd0, 3'd5));
    s = use_stim(3'd5, 3'd5, 1'b1); s.flush = 1'b1;
    step(s);
    check("flush_valid", 32'(ID_EX_valid), 32'd0);
    check("flush_stall", 32'(stall_count), 32'd4);

    // Reset asserted during a stall clears everything.
    step(load_stim(3'd0, 3'd6));
    s = use_stim(3'd6, 3'd0, 1'b0); s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    step(s);
    check("rst_mid_stall", 32'(stall_count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      s = rand_stim();
      s.flush = 1'($urandom_range(0, 9) == 0);
      s.rst   = 1'($urandom_range(0, 49) == 0);
      step(s);
    end

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      step(load_stim(3'd0, 3'd7));
      step(use_stim(3'd7, 3'd0, 1'b0));
    end
    check("sat", 32'(stall_count), 32'd255);

    if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
